conv_output_drain: RTL and testbench

Output-side drain for `conv2d_pe`: snapshots the parallel `conv_output[Hout][Wout][Cout]` array on a capture pulse, then streams it out one 32-bit element per handshake in raster order. Each element carries its (h, w, c) coordinates and a last flag. The block sits between the PE array and downstream writeback/memory logic. It is the consumer/serializer of what the PE array produces in parallel.

---
 rtl/conv_output_drain.sv | 147 ++++++++++++++
 tb/tb_conv_output_drain.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv_output_drain.sv
// conv_output_drain: takes a snapshot of the parallel conv2d_pe result array
// on a capture pulse, then streams it out one element per valid/ready
// handshake in raster order (c fastest, then w, then h).
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   capture     - request to snapshot conv_output (accepted only when idle)
//   conv_output - parallel PE-array result [Hout][Wout][Cout]
//   out_valid/out_ready/out_data/out_h/out_w/out_c/out_last - element stream
//   busy        - high while streaming or finishing
//   done        - one-cycle pulse after the final handshake
//   overrun     - one-cycle pulse when capture arrives while busy
// Optional feature: define CONV_DRAIN_RELU_EN to clamp negative elements
// to zero on the output side (the snapshot itself is not modified).
module conv_output_drain #(
   parameter int Hout = 5,
   parameter int Wout = 5,
   parameter int Cout = 2,
   parameter int DW   = 32,
   localparam int HW  = (Hout > 1) ? $clog2(Hout) : 1,
   localparam int WW  = (Wout > 1) ? $clog2(Wout) : 1,
   localparam int CW  = (Cout > 1) ? $clog2(Cout) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          capture,
   input  logic [DW-1:0] conv_output [0:Hout-1][0:Wout-1][0:Cout-1],
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [HW-1:0] out_h,
   output logic [WW-1:0] out_w,
   output logic [CW-1:0] out_c,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [HW-1:0] h_q, h_d;
   logic [WW-1:0] w_q, w_d;
   logic [CW-1:0] c_q, c_d;
   logic          done_q;
   logic          ovr_q;
   logic          at_last;
   logic [DW-1:0] cur_elem;
   logic [DW-1:0] elem_out;

   logic [DW-1:0] mem_q [0:Hout-1][0:Wout-1][0:Cout-1];

   // Snapshot store; left out of reset since contents are don't-care then.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && capture) begin
         mem_q <= conv_output;
      end
   end

   // Raster-order successor of the current coordinate.
   always_comb begin
      h_d = h_q;
      w_d = w_q;
      c_d = c_q;
      if (c_q == CW'(Cout - 1)) begin
         c_d = '0;
         if (w_q == WW'(Wout - 1)) begin
            w_d = '0;
            h_d = h_q + HW'(1);
         end else begin
            w_d = w_q + WW'(1);
         end
      end else begin
         c_d = c_q + CW'(1);
      end
   end

   assign at_last = (h_q == HW'(Hout - 1)) &&
                    (w_q == WW'(Wout - 1)) &&
                    (c_q == CW'(Cout - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         w_q     <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (capture) begin
                  state_q <= S_STREAM;
                  h_q     <= '0;
                  w_q     <= '0;
                  c_q     <= '0;
               end
            end
            S_STREAM: begin
               ovr_q <= capture;
               if (out_ready) begin
                  if (at_last) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     h_q <= h_d;
                     w_q <= w_d;
                     c_q <= c_d;
                  end
               end
            end
            S_DONE: begin
               ovr_q   <= capture;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cur_elem = mem_q[h_q][w_q][c_q];

`ifdef CONV_DRAIN_RELU_EN
   assign elem_out = cur_elem[DW-1] ? '0 : cur_elem;
`else
   assign elem_out = cur_elem;
`endif

   // Coordinates read zero outside a stream so the idle view is all-zero.
   assign out_valid = (state_q == S_STREAM);
   assign out_data  = out_valid ? elem_out : '0;
   assign out_h     = out_valid ? h_q : '0;
   assign out_w     = out_valid ? w_q : '0;
   assign out_c     = out_valid ? c_q : '0;
   assign out_last  = out_valid && at_last;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_conv_output_drain.sv
// Directed self-checking bench for conv_output_drain (5x5x2, 32-bit).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_conv_output_drain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        capture = 1'b0;
   logic [31:0] conv [0:4][0:4][0:1];
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_h;
   logic [2:0]  out_w;
   logic [0:0]  out_c;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        overrun;

   logic [31:0] exp_mem [0:4][0:4][0:1];
   int          tests = 0;
   int          fails = 0;
   bit          relu_chk = 0;

   always #5 clk = ~clk;

   conv_output_drain dut (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture),
      .conv_output(conv),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_h      (out_h),
      .out_w      (out_w),
      .out_c      (out_c),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_pattern();
      for (int h = 0; h < 5; h++)
         for (int w = 0; w < 5; w++)
            for (int c = 0; c < 2; c++)
               conv[h][w][c] = 32'h100 * h + 32'h10 * w + c;
   endtask

   task automatic fill_dead();
      for (int h = 0; h < 5; h++)
         for (int w = 0; w < 5; w++)
            for (int c = 0; c < 2; c++)
               conv[h][w][c] = 32'hDEAD;
   endtask

   function automatic logic [31:0] exp_elem(input int idx);
      logic [31:0] e;
      e = exp_mem[idx / 10][(idx / 2) % 5][idx % 2];
`ifdef CONV_DRAIN_RELU_EN
      if (e[31]) e = 32'h0;
`endif
      return e;
   endfunction

   task automatic idle_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_hwc"}, {out_h, out_w, out_c}, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ovr"}, overrun, 0);
   endtask

   // Starts at a falling edge with the DUT idle. pat_mode 0 keeps ready high,
   // 1 uses the 1,0,0,1 pattern. ovr_at>=0 fires a rejected capture there.
   // stop_at>=0 returns after that many handshakes without finishing.
   task automatic run_stream(input int pat_mode, input int ovr_at,
                             input int stop_at);
      int idx = 0;
      int cyc = 0;
      int ovr_cnt = 0;
      bit ovr_sent = 0;
      bit pat [4] = '{1, 0, 0, 1};
      exp_mem = conv;
      capture = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      capture = 1'b0;
      while (idx < 50 && idx != stop_at && cyc < 400) begin
         if (overrun) ovr_cnt++;
         capture = 1'b0;
         chk("valid", out_valid, 1);
         chk("busy", busy, 1);
         chk("data", out_data, exp_elem(idx));
         chk("coord", {out_h, out_w, out_c},
             {3'(idx / 10), 3'((idx / 2) % 5), 1'(idx % 2)});
         chk("last", out_last, idx == 49);
         if (relu_chk && idx == 26) chk("e230", out_data, 32'h7);
`ifdef CONV_DRAIN_RELU_EN
         if (relu_chk && idx == 27) chk("e231", out_data, 32'h0);
`else
         if (relu_chk && idx == 27) chk("e231", out_data, 32'hFFFFFFF0);
`endif
         if (idx == ovr_at && !ovr_sent) begin
            capture = 1'b1;
            fill_dead();
            ovr_sent = 1;
         end
         out_ready = (pat_mode == 0) ? 1'b1 : pat[cyc % 4];
         @(negedge clk);
         if (out_ready) idx++;
         cyc++;
      end
      capture = 1'b0;
      out_ready = 1'b0;
      if (stop_at >= 0) begin
         chk("stop_count", idx, stop_at);
         return;
      end
      if (overrun) ovr_cnt++;
      chk("hs_count", idx, 50);
      if (pat_mode == 0) chk("cycles", cyc, 50);
      chk("done_pulse", done, 1);
      chk("valid_in_done", out_valid, 0);
      chk("busy_in_done", busy, 1);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_clear", busy, 0);
      chk("ovr_count", ovr_cnt, (ovr_at >= 0) ? 1 : 0);
   endtask

   initial begin
      fill_pattern();
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         capture = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      idle_zero("reset");
      capture = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      idle_zero("idle");

      // Full stream, ready held high.
      run_stream(0, -1, -1);

      // Backpressure pattern 1,0,0,1.
      run_stream(1, -1, -1);

      // Rejected capture mid-stream while the live input turns to DEAD.
      fill_pattern();
      run_stream(1, 20, -1);

      // Rejected capture coinciding with the final handshake.
      fill_pattern();
      run_stream(0, 49, -1);

      // Reset after ten handshakes.
      fill_pattern();
      run_stream(0, -1, 10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle_zero("mid_reset");
      repeat (3) begin
         @(negedge clk);
         chk("no_done", done, 0);
      end
      run_stream(0, -1, -1);

      // Signed clamp check on elements (2,3,0) and (2,3,1).
      fill_pattern();
      conv[2][3][0] = 32'h7;
      conv[2][3][1] = 32'hFFFFFFF0;
      relu_chk = 1;
      run_stream(0, -1, -1);
      relu_chk = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
